// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, execute redirect and decode handshake.
interface if_fetch_stage_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] imem_rdata;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            id_valid;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc;
   logic            id_ready;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc,
      input  imem_rdata, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc,
      output imem_rdata, redirect_valid, redirect_pc, id_ready
   );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, one-deep in-flight tracking and a prefetch FIFO feeding decode.
// Define IF_BYPASS_EN to forward an arriving response straight to decode when the FIFO is empty.
module if_fetch_stage #(
   parameter int unsigned    XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int unsigned    FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   if_fetch_stage_if.master  bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   entry_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  inflight_pc;
   logic             inflight;

   entry_t           head;
   logic             fifo_empty;
   logic             pop;
   logic             push_fifo;
   logic             pop_fifo;
   logic             issue;
   logic [OCC_W-1:0] occ;
   logic [XLEN-1:0]  redirect_target;
   logic             unused_redirect_lsb;

   assign head                = mem[rd_ptr];
   assign fifo_empty          = (count == '0);
   assign redirect_target     = {bus.redirect_pc[XLEN-1:2], 2'b00};
   assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

`ifdef IF_BYPASS_EN
   logic bypass;

   // Empty FIFO: the arriving response goes straight to decode; it is buffered only if not taken.
   assign bypass       = fifo_empty && inflight && !bus.redirect_valid;
   assign bus.id_valid = !fifo_empty || bypass;
   assign bus.id_instr = bypass ? bus.imem_rdata : head.instr;
   assign bus.id_pc    = bypass ? inflight_pc    : head.pc;
   assign push_fifo    = inflight && !bus.redirect_valid && !(bypass && bus.id_ready);
`else
   assign bus.id_valid = !fifo_empty;
   assign bus.id_instr = head.instr;
   assign bus.id_pc    = head.pc;
   assign push_fifo    = inflight && !bus.redirect_valid;
`endif

   assign pop      = bus.id_valid && bus.id_ready;
   assign pop_fifo = !fifo_empty && bus.id_ready;

   // Occupancy after this cycle's pop, counting the outstanding response as already buffered.
   assign occ   = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
   assign issue = !reset && !bus.redirect_valid && (occ < OCC_W'(FIFO_DEPTH));

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc;

   // PC, in-flight tracking and FIFO bookkeeping; redirect flushes everything and wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= {RESET_PC[XLEN-1:2], 2'b00};
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (bus.redirect_valid) begin
         pc       <= redirect_target;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc          <= pc + XLEN'(4);
            inflight_pc <= pc;
         end
         if (push_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_fifo)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push_fifo) - CNT_W'(pop_fifo);
      end
   end

   // Entry storage; cleared on reset so decode-facing fields start at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      end else if (push_fifo) begin
         mem[wr_ptr] <= '{pc: inflight_pc, instr: bus.imem_rdata};
      end
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming, backpressure, redirect, PC wrap, mid-stream reset.
module tb_if_fetch_stage;
   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   if_fetch_stage_if #(.XLEN(32)) bus ();

   if_fetch_stage #(
      .XLEN      (32),
      .RESET_PC  (32'h0000_0000),
      .FIFO_DEPTH(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Synchronous memory: data one cycle after the request, garbage otherwise.
   always @(posedge clk)
      bus.imem_rdata <= bus.imem_req ? instr_of(bus.imem_addr) : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic req, input logic [31:0] addr,
                      input logic vld, input logic [31:0] pc);
      #1;
      check({tag, ".req"},  32'(bus.imem_req), 32'(req));
      check({tag, ".addr"}, bus.imem_addr,     addr);
      check({tag, ".vld"},  32'(bus.id_valid), 32'(vld));
      if (vld) begin
         check({tag, ".pc"},    bus.id_pc,    pc);
         check({tag, ".instr"}, bus.id_instr, instr_of(pc));
      end
   endtask

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      reset              = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.id_ready       = rdy;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      reset              = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.id_ready       = 1'b1;
      repeat (2) @(negedge clk);
      cyc("rst", 1'b0, 32'h0, 1'b0, 32'h0);
      check("rst.instr", bus.id_instr, 32'h0);
      check("rst.pc",    bus.id_pc,    32'h0);

`ifdef IF_BYPASS_EN
      @(negedge clk); reset = 1'b0;
      cyc("b1c0", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("b1c1", 1'b1, 32'h4, 1'b1, 32'h0);
      @(negedge clk); cyc("b1c2", 1'b1, 32'h8, 1'b1, 32'h4);

      do_reset(1'b0);
      cyc("b2c0", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("b2c1", 1'b1, 32'h4, 1'b1, 32'h0);
      @(negedge clk); cyc("b2c2", 1'b0, 32'h8, 1'b1, 32'h0);
      @(negedge clk); cyc("b2c3", 1'b0, 32'h8, 1'b1, 32'h0);
      @(negedge clk); bus.id_ready = 1'b1;
      cyc("b2c4", 1'b1, 32'h8, 1'b1, 32'h0);
      @(negedge clk); cyc("b2c5", 1'b1, 32'hC,  1'b1, 32'h4);
      @(negedge clk); cyc("b2c6", 1'b1, 32'h10, 1'b1, 32'h8);
`else
      // Streaming after reset release
      @(negedge clk); reset = 1'b0;
      cyc("t1c0", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("t1c1", 1'b1, 32'h4,  1'b0, 32'h0);
      @(negedge clk); cyc("t1c2", 1'b1, 32'h8,  1'b1, 32'h0);
      @(negedge clk); cyc("t1c3", 1'b1, 32'hC,  1'b1, 32'h4);
      @(negedge clk); cyc("t1c4", 1'b1, 32'h10, 1'b1, 32'h8);

      // Backpressure fills the FIFO, then drains in order
      do_reset(1'b0);
      cyc("t2c0", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("t2c1", 1'b1, 32'h4, 1'b0, 32'h0);
      @(negedge clk); cyc("t2c2", 1'b0, 32'h8, 1'b1, 32'h0);
      @(negedge clk); cyc("t2c3", 1'b0, 32'h8, 1'b1, 32'h0);
      @(negedge clk); cyc("t2c4", 1'b0, 32'h8, 1'b1, 32'h0);
      @(negedge clk); bus.id_ready = 1'b1;
      cyc("t2c5", 1'b1, 32'h8, 1'b1, 32'h0);
      @(negedge clk); cyc("t2c6", 1'b1, 32'hC,  1'b1, 32'h4);
      @(negedge clk); cyc("t2c7", 1'b1, 32'h10, 1'b1, 32'h8);
      @(negedge clk); cyc("t2c8", 1'b1, 32'h14, 1'b1, 32'hC);

      // Asynchronous reset with a full FIFO, then restart from RESET_PC
      do_reset(1'b0);
      cyc("t5c0", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("t5c1", 1'b1, 32'h4, 1'b0, 32'h0);
      @(negedge clk); cyc("t5c2", 1'b0, 32'h8, 1'b1, 32'h0);
      @(negedge clk); cyc("t5c3", 1'b0, 32'h8, 1'b1, 32'h0);
      reset = 1'b1;
      cyc("t5rst", 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk); reset = 1'b0; bus.id_ready = 1'b1;
      cyc("t5r0", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("t5r1", 1'b1, 32'h4, 1'b0, 32'h0);
      @(negedge clk); cyc("t5r2", 1'b1, 32'h8, 1'b1, 32'h0);

      // Redirect with in-flight response, same-cycle push and pop
      do_reset(1'b1);
      cyc("t3c0", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("t3c1", 1'b1, 32'h4, 1'b0, 32'h0);
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103;
      cyc("t3r", 1'b0, 32'h8, 1'b1, 32'h0);
      @(negedge clk); bus.redirect_valid = 1'b0;
      cyc("t3r1", 1'b1, 32'h100, 1'b0, 32'h0);
      @(negedge clk); cyc("t3r2", 1'b1, 32'h104, 1'b0, 32'h0);
      @(negedge clk); cyc("t3r3", 1'b1, 32'h108, 1'b1, 32'h100);
      @(negedge clk); cyc("t3r4", 1'b1, 32'h10C, 1'b1, 32'h104);
      @(negedge clk); cyc("t3r5", 1'b1, 32'h110, 1'b1, 32'h108);

      // Redirect near the top of the address space: alignment and PC wrap
      @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE;
      cyc("w0", 1'b0, 32'h114, 1'b1, 32'h10C);
      @(negedge clk); bus.redirect_valid = 1'b0;
      cyc("w1", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      @(negedge clk); cyc("w2", 1'b1, 32'h0, 1'b0, 32'h0);
      @(negedge clk); cyc("w3", 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC);
      @(negedge clk); cyc("w4", 1'b1, 32'h8, 1'b1, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
